// File: rtl/slot_sequencer.sv
// Walks the descriptor slot table, issues PENDING slots to the DMA engine and
// writes back the final status plus an ISSUE+WAIT cycle-count profile per slot.
module slot_sequencer #(
    parameter int INDEX_WIDTH    = 2,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int STATUS_WIDTH   = 2,
    parameter int PROFILE_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [INDEX_WIDTH-1:0]    last_index,
    input  logic                      stop_on_err,
    output logic                      busy,
    output logic                      seq_done,
    output logic                      err_flag,
    output logic [INDEX_WIDTH-1:0]    rd_index,
    input  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
    input  logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0] rd_des_size,
    input  logic [STATUS_WIDTH-1:0]   rd_status,
    output logic [INDEX_WIDTH-1:0]    wr_index,
    output logic [STATUS_WIDTH-1:0]   wr_status,
    output logic [PROFILE_WIDTH-1:0]  wr_profile,
    output logic                      set_status,
    output logic                      set_profile,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] cmd_src_size,
    output logic [DST_ADDR_WIDTH-1:0] cmd_des_addr,
    output logic [DST_SIZE_WIDTH-1:0] cmd_des_size,
    input  logic                      dma_done,
    input  logic                      dma_err
);

    localparam logic [STATUS_WIDTH-1:0] ST_PENDING = STATUS_WIDTH'(1);
    localparam logic [STATUS_WIDTH-1:0] ST_DONE    = STATUS_WIDTH'(2);
    localparam logic [STATUS_WIDTH-1:0] ST_ERROR   = STATUS_WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WRBACK,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [INDEX_WIDTH-1:0]     cur;
    logic [INDEX_WIDTH-1:0]     last_q;
    logic                       stop_q;
    logic [STATUS_WIDTH-1:0]    status_q;
    logic [PROFILE_WIDTH-1:0]   prof;

    // Profile counter sticks at all-ones instead of wrapping.
    function automatic logic [PROFILE_WIDTH-1:0] sat_inc(input logic [PROFILE_WIDTH-1:0] v);
        return (&v) ? v : v + PROFILE_WIDTH'(1);
    endfunction

    assign rd_index   = cur;
    assign wr_index   = cur;
    assign wr_status  = status_q;
    assign wr_profile = prof;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != S_IDLE);
        seq_done    = 1'b0;
        cmd_valid   = 1'b0;
        set_status  = 1'b0;
        set_profile = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = (rd_status == ST_PENDING) ? S_ISSUE : S_NEXT;
            S_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_nxt = S_WAIT;
            end
            S_WAIT:   if (dma_done) state_nxt = S_WRBACK;
            S_WRBACK: begin
                set_status  = 1'b1;
                set_profile = 1'b1;
                state_nxt   = (status_q == ST_ERROR && stop_q) ? S_FINISH : S_NEXT;
            end
            S_NEXT:   state_nxt = (cur == last_q) ? S_FINISH : S_FETCH;
            S_FINISH: begin
                seq_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Pass context, captured payload and the profile counter; all cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur          <= '0;
            last_q       <= '0;
            stop_q       <= 1'b0;
            err_flag     <= 1'b0;
            status_q     <= '0;
            prof         <= '0;
            cmd_src_addr <= '0;
            cmd_src_size <= '0;
            cmd_des_addr <= '0;
            cmd_des_size <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur      <= '0;
                        last_q   <= last_index;
                        stop_q   <= stop_on_err;
                        err_flag <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (rd_status == ST_PENDING) begin
                        cmd_src_addr <= rd_src_addr;
                        cmd_src_size <= rd_src_size;
                        cmd_des_addr <= rd_des_addr;
                        cmd_des_size <= rd_des_size;
                        prof         <= '0;
                    end
                end
                S_ISSUE: prof <= sat_inc(prof);
                S_WAIT: begin
                    prof <= sat_inc(prof);
                    if (dma_done) status_q <= dma_err ? ST_ERROR : ST_DONE;
                end
                S_WRBACK: begin
                    if (status_q == ST_ERROR) err_flag <= 1'b1;
                end
                S_NEXT: begin
                    if (cur != last_q) cur <= cur + INDEX_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_sequencer.sv
// Directed bench for slot_sequencer: slot table model, DMA responder, and a
// narrow-profile twin instance that runs in lockstep to exercise saturation.
module tb_slot_sequencer;

    localparam int IW = 2, SAW = 32, SSW = 26, DAW = 32, DSW = 26, SW = 2, PW = 32, NPW = 4;
    localparam logic [SW-1:0] EMP = 2'd0, PEN = 2'd1, DON = 2'd2, ERR = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, stop_on_err, cmd_ready, dma_done, dma_err;
    logic [IW-1:0]  last_index;
    logic           busy, seq_done, err_flag, set_status, set_profile, cmd_valid;
    logic [IW-1:0]  rd_index, wr_index;
    logic [SW-1:0]  wr_status;
    logic [PW-1:0]  wr_profile;
    logic [SAW-1:0] cmd_src_addr, rd_src_addr;
    logic [SSW-1:0] cmd_src_size, rd_src_size;
    logic [DAW-1:0] cmd_des_addr, rd_des_addr;
    logic [DSW-1:0] cmd_des_size, rd_des_size;
    logic [SW-1:0]  rd_status;

    logic           n_busy, n_seq_done, n_err_flag, n_set_status, n_set_profile, n_cmd_valid;
    logic [IW-1:0]  n_rd_index, n_wr_index;
    logic [SW-1:0]  n_wr_status;
    logic [NPW-1:0] n_wr_profile;
    logic [SAW-1:0] n_cmd_src_addr;
    logic [SSW-1:0] n_cmd_src_size;
    logic [DAW-1:0] n_cmd_des_addr;
    logic [DSW-1:0] n_cmd_des_size;

    logic [SAW-1:0] tbl_src_addr [4];
    logic [SSW-1:0] tbl_src_size [4];
    logic [DAW-1:0] tbl_des_addr [4];
    logic [DSW-1:0] tbl_des_size [4];
    logic [SW-1:0]  tbl_status   [4];
    logic           wb_valid     [4];
    logic [SW-1:0]  wb_status    [4];
    logic [PW-1:0]  wb_prof      [4];
    logic [NPW-1:0] nwb_prof     [4];

    assign rd_src_addr = tbl_src_addr[rd_index];
    assign rd_src_size = tbl_src_size[rd_index];
    assign rd_des_addr = tbl_des_addr[rd_index];
    assign rd_des_size = tbl_des_size[rd_index];
    assign rd_status   = wb_valid[rd_index] ? wb_status[rd_index] : tbl_status[rd_index];

    slot_sequencer #(.INDEX_WIDTH(IW), .SRC_ADDR_WIDTH(SAW), .SRC_SIZE_WIDTH(SSW),
                     .DST_ADDR_WIDTH(DAW), .DST_SIZE_WIDTH(DSW), .STATUS_WIDTH(SW),
                     .PROFILE_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .last_index(last_index),
        .stop_on_err(stop_on_err), .busy(busy), .seq_done(seq_done), .err_flag(err_flag),
        .rd_index(rd_index), .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
        .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size), .rd_status(rd_status),
        .wr_index(wr_index), .wr_status(wr_status), .wr_profile(wr_profile),
        .set_status(set_status), .set_profile(set_profile), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_src_addr(cmd_src_addr), .cmd_src_size(cmd_src_size),
        .cmd_des_addr(cmd_des_addr), .cmd_des_size(cmd_des_size),
        .dma_done(dma_done), .dma_err(dma_err)
    );

    slot_sequencer #(.INDEX_WIDTH(IW), .SRC_ADDR_WIDTH(SAW), .SRC_SIZE_WIDTH(SSW),
                     .DST_ADDR_WIDTH(DAW), .DST_SIZE_WIDTH(DSW), .STATUS_WIDTH(SW),
                     .PROFILE_WIDTH(NPW)) dut_narrow (
        .clk(clk), .reset(reset), .start(start), .last_index(last_index),
        .stop_on_err(stop_on_err), .busy(n_busy), .seq_done(n_seq_done), .err_flag(n_err_flag),
        .rd_index(n_rd_index), .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
        .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size), .rd_status(rd_status),
        .wr_index(n_wr_index), .wr_status(n_wr_status), .wr_profile(n_wr_profile),
        .set_status(n_set_status), .set_profile(n_set_profile), .cmd_valid(n_cmd_valid),
        .cmd_ready(cmd_ready), .cmd_src_addr(n_cmd_src_addr), .cmd_src_size(n_cmd_src_size),
        .cmd_des_addr(n_cmd_des_addr), .cmd_des_size(n_cmd_des_size),
        .dma_done(dma_done), .dma_err(dma_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cmd_log[$];
    int done_dly = 5;
    int err_slot = -1;
    int seq_cnt = 0;
    int dma_slot;
    int test_id = 0;
    logic load_req = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // DMA responder: logs each accepted command and answers done_dly cycles later.
    initial begin
        dma_done = 1'b0;
        dma_err  = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (reset && cmd_valid && cmd_ready) begin
                dma_slot = -1;
                for (int i = 0; i < 4; i++)
                    if (tbl_src_addr[i] == cmd_src_addr) dma_slot = i;
                cmd_log.push_back(dma_slot);
                if (dma_slot < 0) dma_slot = 0;
                chk("cmd_payload", {cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size},
                    {tbl_src_addr[dma_slot], tbl_src_size[dma_slot],
                     tbl_des_addr[dma_slot], tbl_des_size[dma_slot]});
                @(posedge clk);
                repeat (done_dly - 1) @(posedge clk);
                #1 dma_done = 1'b1;
                dma_err  = (dma_slot == err_slot);
                @(posedge clk);
                #1 dma_done = 1'b0;
                dma_err  = 1'b0;
            end
        end
    end

    // Slot table write port and seq_done counter.
    initial begin
        for (int i = 0; i < 4; i++) wb_valid[i] = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (load_req) begin
                for (int i = 0; i < 4; i++) wb_valid[i] = 1'b0;
            end else if (set_status && set_profile) begin
                wb_valid[wr_index]  = 1'b1;
                wb_status[wr_index] = wr_status;
                wb_prof[wr_index]   = wr_profile;
            end
            if (n_set_profile) nwb_prof[n_wr_index] = n_wr_profile;
            if (seq_done) seq_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    task automatic load(input int tag, input logic [SW-1:0] s0, s1, s2, s3);
        for (int i = 0; i < 4; i++) begin
            tbl_src_addr[i] = {8'hA0, 8'(tag), 14'd0, 2'(i)};
            tbl_src_size[i] = 26'(1000 * tag + 17 * i + 1);
            tbl_des_addr[i] = {8'hB0, 8'(tag), 14'h3ff, 2'(i)};
            tbl_des_size[i] = 26'(500 * tag + 29 * i + 3);
        end
        tbl_status[0] = s0; tbl_status[1] = s1; tbl_status[2] = s2; tbl_status[3] = s3;
        load_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [IW-1:0] li, input logic soe);
        last_index  = li;
        stop_on_err = soe;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("t%0d_busy_after_start", test_id), busy, 1'b1);
        chk($sformatf("t%0d_err_clear_on_start", test_id), err_flag, 1'b0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!seq_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("t%0d_seq_done_seen", test_id), seq_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_slot(input int i, input logic w, input logic [SW-1:0] st, input int pf);
        chk($sformatf("t%0d_slot%0d_written", test_id, i), wb_valid[i], w);
        if (w) begin
            chk($sformatf("t%0d_slot%0d_status", test_id, i), wb_status[i], st);
            chk($sformatf("t%0d_slot%0d_profile", test_id, i), wb_prof[i], pf);
        end
    endtask

    task automatic chk_log(input int base, input int n, input int e0, e1, e2, e3);
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk($sformatf("t%0d_cmd_count", test_id), cmd_log.size() - base, n);
        for (int k = 0; k < n; k++)
            if (base + k < cmd_log.size())
                chk($sformatf("t%0d_cmd%0d_slot", test_id, k), cmd_log[base + k], e[k]);
    endtask

    int cyc, base, sc, cnt;

    initial begin
        reset = 1'b0; start = 1'b0; last_index = '0; stop_on_err = 1'b0; cmd_ready = 1'b1;
        load(0, PEN, PEN, PEN, PEN);
        chk("reset_ctrl", {busy, seq_done, err_flag, set_status, set_profile, cmd_valid,
                           rd_index, wr_index, wr_status}, '0);
        chk("reset_data", {wr_profile, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size}, '0);
        chk("reset_narrow", {n_busy, n_seq_done, n_err_flag, n_set_status, n_set_profile,
                             n_cmd_valid, n_rd_index, n_wr_index, n_wr_status, n_wr_profile,
                             n_cmd_src_addr, n_cmd_src_size, n_cmd_des_addr, n_cmd_des_size}, '0);
        reset = 1'b1;
        @(negedge clk);

        // 1: all pending, latency and write-back
        test_id = 1;
        load(1, PEN, PEN, PEN, PEN);
        base = cmd_log.size(); sc = seq_cnt;
        do_start(2'd3, 1'b0);
        wait_done(cyc);
        chk("t1_latency", cyc, 37);
        chk_log(base, 4, 0, 1, 2, 3);
        for (int i = 0; i < 4; i++) chk_slot(i, 1'b1, DON, 6);
        chk("t1_seq_done_pulses", seq_cnt - sc, 1);
        chk("t1_err_flag", err_flag, 1'b0);
        chk("t1_idle", busy, 1'b0);

        // 2: empty slot skipped
        test_id = 2;
        load(2, PEN, EMP, PEN, PEN);
        base = cmd_log.size();
        do_start(2'd3, 1'b0);
        wait_done(cyc);
        chk_log(base, 3, 0, 2, 3, 0);
        chk_slot(0, 1'b1, DON, 6);
        chk_slot(1, 1'b0, EMP, 0);
        chk_slot(2, 1'b1, DON, 6);
        chk_slot(3, 1'b1, DON, 6);

        // 3a: stop on error at slot1
        test_id = 3;
        load(3, PEN, PEN, PEN, PEN);
        err_slot = 1;
        base = cmd_log.size(); sc = seq_cnt;
        do_start(2'd3, 1'b1);
        wait_done(cyc);
        chk_log(base, 2, 0, 1, 0, 0);
        chk_slot(0, 1'b1, DON, 6);
        chk_slot(1, 1'b1, ERR, 6);
        chk_slot(2, 1'b0, EMP, 0);
        chk_slot(3, 1'b0, EMP, 0);
        chk("t3_seq_done_pulses", seq_cnt - sc, 1);
        chk("t3_err_flag", err_flag, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_err_flag_sticky", err_flag, 1'b1);

        // 3b: same error, keep going
        test_id = 4;
        load(4, PEN, PEN, PEN, PEN);
        base = cmd_log.size();
        do_start(2'd3, 1'b0);
        wait_done(cyc);
        chk_log(base, 4, 0, 1, 2, 3);
        chk_slot(1, 1'b1, ERR, 6);
        chk_slot(2, 1'b1, DON, 6);
        chk_slot(3, 1'b1, DON, 6);
        chk("t4_err_flag", err_flag, 1'b1);
        err_slot = -1;

        // 4: backpressure on slot0
        test_id = 5;
        load(5, PEN, PEN, PEN, PEN);
        cmd_ready = 1'b0;
        base = cmd_log.size();
        do_start(2'd0, 1'b0);
        cnt = 0;
        while (!cmd_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5_hold%0d_valid", k), cmd_valid, 1'b1);
            chk($sformatf("t5_hold%0d_payload", k),
                {cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size},
                {tbl_src_addr[0], tbl_src_size[0], tbl_des_addr[0], tbl_des_size[0]});
            @(negedge clk);
        end
        chk("t5_valid_before_ready", cmd_valid, 1'b1);
        cmd_ready = 1'b1;
        wait_done(cyc);
        chk_log(base, 1, 0, 0, 0, 0);
        chk_slot(0, 1'b1, DON, 9);
        chk_slot(1, 1'b0, EMP, 0);

        // 5: reset during WAIT of slot2, then resume
        test_id = 6;
        load(6, PEN, PEN, PEN, PEN);
        base = cmd_log.size();
        do_start(2'd3, 1'b0);
        cnt = 0;
        while (cmd_log.size() - base < 3 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t6_async_reset_ctrl", {busy, seq_done, err_flag, set_status, set_profile, cmd_valid,
                                    rd_index, wr_index, wr_status}, '0);
        chk("t6_async_reset_data", {wr_profile, cmd_src_addr, cmd_src_size, cmd_des_addr,
                                    cmd_des_size}, '0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_idle_after_reset", busy, 1'b0);
        chk_slot(0, 1'b1, DON, 6);
        chk_slot(1, 1'b1, DON, 6);
        chk_slot(2, 1'b0, EMP, 0);
        chk_slot(3, 1'b0, EMP, 0);
        base = cmd_log.size();
        do_start(2'd3, 1'b0);
        wait_done(cyc);
        chk_log(base, 2, 2, 3, 0, 0);
        chk_slot(2, 1'b1, DON, 6);
        chk_slot(3, 1'b1, DON, 6);

        // 6: long DMA, saturation in the narrow twin, starts while busy
        test_id = 7;
        done_dly = 20;
        load(7, PEN, PEN, PEN, PEN);
        base = cmd_log.size(); sc = seq_cnt;
        do_start(2'd1, 1'b0);
        repeat (3) @(negedge clk);
        last_index = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (cmd_log.size() - base < 2 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        last_index = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk_log(base, 2, 0, 1, 0, 0);
        chk_slot(0, 1'b1, DON, 21);
        chk_slot(1, 1'b1, DON, 21);
        chk_slot(2, 1'b0, EMP, 0);
        chk("t7_narrow_prof0", nwb_prof[0], 4'hf);
        chk("t7_narrow_prof1", nwb_prof[1], 4'hf);
        chk("t7_seq_done_pulses", seq_cnt - sc, 1);
        repeat (4) @(negedge clk);
        chk("t7_idle", busy, 1'b0);
        done_dly = 5;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
